// File: rtl/x25519_pkg.sv
// Shared X25519 definitions: field-element type, base point, DH controller
// state encoding and scalar clamping, also reused by key-management blocks.
package x25519_pkg;

  typedef logic [254:0] fe_t;

  localparam fe_t BASE_U_DEFAULT = 255'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUB_RUN = 2'd1,
    ST_KEYED   = 2'd2,
    ST_SH_RUN  = 2'd3
  } dh_state_e;

  // Bit 254 of the seed is dropped: the clamped scalar always has bit 254 set
  // and a multiple-of-8 value (cofactor clearing).
  function automatic fe_t clamp(input fe_t s);
    return {1'b1, s[253:3], 3'b000};
  endfunction

endpackage

// File: rtl/x25519_dh_ctrl.sv
// X25519 Diffie-Hellman sequencer: public-key generation on load, shared secret
// on peer_valid, driving one external curve25519 scalar-multiplication core.
module x25519_dh_ctrl
  import x25519_pkg::*;
#(
  parameter fe_t BASE_U = BASE_U_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [254:0] secret,
  input  logic         peer_valid,
  input  logic [254:0] peer_key,
  output logic         busy,
  output logic         public_valid,
  output logic [254:0] public_key,
  output logic         shared_valid,
  output logic [254:0] shared,
  output logic         shared_zero,
  output logic         err,
  output logic         core_start,
  output logic [254:0] core_scalar,
  output logic [254:0] core_point,
  input  logic         core_done,
  input  logic [254:0] core_out
);

  dh_state_e state_q, state_d;
  logic      armed_q, armed_d;
  fe_t       scalar_q, scalar_d;
  fe_t       public_key_q, public_key_d;
  fe_t       shared_q, shared_d;
  logic      shared_zero_q, shared_zero_d;
  logic      public_valid_q, public_valid_d;
  logic      shared_valid_q, shared_valid_d;
  logic      err_q, err_d;
  logic      core_start_q, core_start_d;
  fe_t       core_scalar_q, core_scalar_d;
  fe_t       core_point_q, core_point_d;

  logic load_ok, peer_ok, done_acc;
  fe_t  clamped;

  // The core idles with done high, so a done only counts once it has been
  // seen low after our start; this also masks a done left over across reset.
  assign done_acc = armed_q & core_done;
  assign load_ok  = load & ((state_q == ST_IDLE) | (state_q == ST_KEYED));
  assign peer_ok  = peer_valid & ~load & (state_q == ST_KEYED);
  assign clamped  = clamp(secret);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load_ok) state_d = ST_PUB_RUN;
      ST_KEYED: begin
        if (load_ok)      state_d = ST_PUB_RUN;
        else if (peer_ok) state_d = ST_SH_RUN;
      end
      ST_PUB_RUN: if (done_acc) state_d = ST_KEYED;
      ST_SH_RUN:  if (done_acc) state_d = ST_KEYED;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    armed_d        = armed_q;
    scalar_d       = scalar_q;
    public_key_d   = public_key_q;
    shared_d       = shared_q;
    shared_zero_d  = shared_zero_q;
    public_valid_d = 1'b0;
    shared_valid_d = 1'b0;
    core_start_d   = 1'b0;
    core_scalar_d  = core_scalar_q;
    core_point_d   = core_point_q;
    err_d          = (peer_valid & ~peer_ok) | (load & ~load_ok);

    if (!core_done) armed_d = 1'b1;

    if (load_ok) begin
      scalar_d      = clamped;
      core_scalar_d = clamped;
      core_point_d  = BASE_U;
      core_start_d  = 1'b1;
      armed_d       = 1'b0;
    end else if (peer_ok) begin
      core_scalar_d = scalar_q;
      core_point_d  = peer_key;
      core_start_d  = 1'b1;
      armed_d       = 1'b0;
    end

    if (done_acc && state_q == ST_PUB_RUN) begin
      public_key_d   = core_out;
      public_valid_d = 1'b1;
    end
    if (done_acc && state_q == ST_SH_RUN) begin
      shared_d       = core_out;
      shared_zero_d  = (core_out == '0);
      shared_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      armed_q        <= 1'b0;
      scalar_q       <= '0;
      public_key_q   <= '0;
      shared_q       <= '0;
      shared_zero_q  <= 1'b0;
      public_valid_q <= 1'b0;
      shared_valid_q <= 1'b0;
      err_q          <= 1'b0;
      core_start_q   <= 1'b0;
      core_scalar_q  <= '0;
      core_point_q   <= '0;
    end else begin
      armed_q        <= armed_d;
      scalar_q       <= scalar_d;
      public_key_q   <= public_key_d;
      shared_q       <= shared_d;
      shared_zero_q  <= shared_zero_d;
      public_valid_q <= public_valid_d;
      shared_valid_q <= shared_valid_d;
      err_q          <= err_d;
      core_start_q   <= core_start_d;
      core_scalar_q  <= core_scalar_d;
      core_point_q   <= core_point_d;
    end
  end

  assign busy         = (state_q == ST_PUB_RUN) | (state_q == ST_SH_RUN);
  assign public_valid = public_valid_q;
  assign public_key   = public_key_q;
  assign shared_valid = shared_valid_q;
  assign shared       = shared_q;
  assign shared_zero  = shared_zero_q;
  assign err          = err_q;
  assign core_start   = core_start_q;
  assign core_scalar  = core_scalar_q;
  assign core_point   = core_point_q;

endmodule

// File: tb/tb_x25519_dh_ctrl.sv
// Directed bench for x25519_dh_ctrl with a stand-in core whose result is
// scalar ^ point (0 for a zero point) after a fixed latency.
module tb_x25519_dh_ctrl;
  import x25519_pkg::*;

  localparam int LAT = 4;
  localparam int EV_PUB = 0, EV_SH = 1;

  logic clock = 1'b0, reset = 1'b1, load = 1'b0, peer_valid = 1'b0;
  fe_t  secret = '0, peer_key = '0;
  logic busy, public_valid, shared_valid, shared_zero, err, core_start;
  fe_t  public_key, shared, core_scalar, core_point;
  logic core_done = 1'b1;
  fe_t  core_out = '0;

  x25519_dh_ctrl dut (
    .clock(clock), .reset(reset), .load(load), .secret(secret),
    .peer_valid(peer_valid), .peer_key(peer_key), .busy(busy),
    .public_valid(public_valid), .public_key(public_key),
    .shared_valid(shared_valid), .shared(shared), .shared_zero(shared_zero),
    .err(err), .core_start(core_start), .core_scalar(core_scalar),
    .core_point(core_point), .core_done(core_done), .core_out(core_out)
  );

  always #5 clock = ~clock;

  // Core model: optional stale-done hold, then done low for LAT cycles.
  int   stale_hold = 0, m_hold = 0, m_cnt = 0;
  logic m_busy = 1'b0;
  fe_t  m_s = '0, m_p = '0;
  always @(posedge clock) begin
    if (core_start) begin
      m_hold   <= stale_hold;
      m_cnt    <= LAT;
      m_s      <= core_scalar;
      m_p      <= core_point;
      m_busy   <= 1'b1;
      core_out <= {16'hDEAD, 239'd0};
    end else if (m_busy) begin
      if (m_hold > 0) m_hold <= m_hold - 1;
      else if (m_cnt > 0) begin
        core_done <= 1'b0;
        m_cnt     <= m_cnt - 1;
      end else begin
        core_done <= 1'b1;
        core_out  <= (m_p == '0) ? '0 : (m_s ^ m_p);
        m_busy    <= 1'b0;
      end
    end
  end

  int n_start = 0, n_pub = 0, n_sh = 0, n_err = 0;
  always @(negedge clock) begin
    n_start <= n_start + int'(core_start);
    n_pub   <= n_pub + int'(public_valid);
    n_sh    <= n_sh + int'(shared_valid);
    n_err   <= n_err + int'(err);
  end

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string name, input fe_t act, input fe_t exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic req(input logic l, input fe_t s, input logic pv, input fe_t pk);
    @(negedge clock);
    load = l; secret = s; peer_valid = pv; peer_key = pk;
    @(negedge clock);
    load = 1'b0; peer_valid = 1'b0;
    #1;
  endtask

  task automatic wait_ev(input int which, input int base, input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clock); #1;
      if (((which == EV_PUB) ? n_pub : n_sh) > base) return;
    end
    n_vec++; n_miss++;
    $display("FAIL %s: timeout waiting for result pulse", name);
  endtask

  typedef struct {
    fe_t  secret;
    fe_t  peer;
    fe_t  clamp_exp;
    fe_t  pub_exp;
    fe_t  sh_exp;
    logic zero_exp;
  } vec_t;
  vec_t vt[3];

  localparam fe_t C0   = {1'b1, 254'd0};
  localparam fe_t P0   = {1'b1, 250'd0, 4'h9};
  localparam fe_t C1S  = {1'b1, {246{1'b1}}, 8'hF8};
  localparam fe_t P1S  = {1'b1, {246{1'b1}}, 8'hF1};
  localparam fe_t S1S5 = {1'b1, {246{1'b1}}, 8'hFD};

  initial begin
    int b, e, bs;
    vt[0] = '{255'd0, 255'hFFFF, C0, P0, {1'b1, 238'd0, 16'hFFFF}, 1'b0};
    vt[1] = '{255'h1234567F, 255'd0, {1'b1, 222'd0, 32'h12345678},
              {1'b1, 222'd0, 32'h12345671}, 255'd0, 1'b1};
    vt[2] = '{{255{1'b1}}, 255'd5, C1S, P1S, S1S5, 1'b0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_ctl", {busy, public_valid, shared_valid, shared_zero, err, core_start}, '0);
    chk("reset_pub", public_key, '0);
    chk("reset_shared", shared, '0);
    chk("reset_scalar", core_scalar, '0);
    chk("reset_point", core_point, '0);

    // peer_valid in IDLE is rejected
    b = n_start;
    req(1'b0, '0, 1'b1, 255'd5);
    chk("idle_peer_err", err, 1'b1);
    chk("idle_peer_busy", busy, 1'b0);
    @(negedge clock); #1;
    chk("idle_peer_nostart", n_start - b, 0);

    foreach (vt[i]) begin
      b = n_start; e = n_pub;
      req(1'b1, vt[i].secret, 1'b0, '0);
      chk($sformatf("v%0d_start", i), core_start, 1'b1);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      chk($sformatf("v%0d_scalar", i), core_scalar, vt[i].clamp_exp);
      chk($sformatf("v%0d_point", i), core_point, 255'd9);
      wait_ev(EV_PUB, e, $sformatf("v%0d_pubwait", i));
      chk($sformatf("v%0d_pub", i), public_key, vt[i].pub_exp);
      chk($sformatf("v%0d_idlebusy", i), busy, 1'b0);
      chk($sformatf("v%0d_onestart", i), n_start - b, 1);
      bs = n_sh;
      req(1'b0, '0, 1'b1, vt[i].peer);
      chk($sformatf("v%0d_shscalar", i), core_scalar, vt[i].clamp_exp);
      chk($sformatf("v%0d_shpoint", i), core_point, vt[i].peer);
      wait_ev(EV_SH, bs, $sformatf("v%0d_shwait", i));
      chk($sformatf("v%0d_shared", i), shared, vt[i].sh_exp);
      chk($sformatf("v%0d_zero", i), shared_zero, vt[i].zero_exp);
    end

    // load during PUB_RUN is rejected and starts nothing
    e = n_pub;
    req(1'b1, '0, 1'b0, '0);
    b = n_start;
    req(1'b1, {255{1'b1}}, 1'b0, '0);
    chk("pubrun_load_err", err, 1'b1);
    wait_ev(EV_PUB, e, "pubrun_wait");
    chk("pubrun_nostart", n_start - b, 0);
    chk("pubrun_pub", public_key, P0);
    chk("pubrun_scalar", core_scalar, C0);

    // load and peer_valid together in KEYED: load wins, one err
    b = n_err; e = n_pub;
    req(1'b1, {255{1'b1}}, 1'b1, 255'd5);
    chk("both_err", err, 1'b1);
    chk("both_scalar", core_scalar, C1S);
    chk("both_point", core_point, 255'd9);
    wait_ev(EV_PUB, e, "both_wait");
    chk("both_pub", public_key, P1S);
    chk("both_errcnt", n_err - b, 1);

    // stale done held high after start must not be taken
    stale_hold = 3;
    bs = n_sh;
    req(1'b0, '0, 1'b1, 255'd5);
    repeat (4) @(negedge clock);
    #1;
    chk("stale_nopulse", n_sh - bs, 0);
    wait_ev(EV_SH, bs, "stale_wait");
    chk("stale_shared", shared, S1S5);
    stale_hold = 0;

    // reset during SH_RUN abandons the operation
    bs = n_sh;
    req(1'b0, '0, 1'b1, 255'h77);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ctl", {busy, shared_valid, shared_zero, err, core_start}, '0);
    chk("rst_pub", public_key, '0);
    chk("rst_shared", shared, '0);
    chk("rst_scalar", core_scalar, '0);
    repeat (LAT + 6) @(negedge clock);
    #1;
    chk("rst_nopulse", n_sh - bs, 0);
    e = n_pub;
    req(1'b1, '0, 1'b0, '0);
    wait_ev(EV_PUB, e, "rst_pubwait");
    chk("rst_pub_after", public_key, P0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/x25519_dh_ctrl.md
# x25519_dh_ctrl

Hardware initiator for a complete X25519 Diffie-Hellman exchange. It sits between a host-side key interface and one `curve25519` scalar-multiplication core, and drives that core's `start`/`scalar`/`point` inputs and consumes its `done`/`out`. On `load` it clamps the secret and computes the public key (scalar times base point 9). On `peer_valid` it computes the shared secret from the peer's public key and flags the all-zero (low-order point) result.

## Interface
Parameters:
- `BASE_U`, default 255'd9: base-point u-coordinate used for public-key generation.

Ports:
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `load`  in  1: single-cycle request to take a new secret.
- `secret`  in  255: raw secret seed, sampled when `load` is accepted.
- `peer_valid`  in  1: single-cycle request to compute the shared secret.
- `peer_key`  in  255: peer public u-coordinate, sampled when `peer_valid` is accepted.
- `busy`  out  1: high while a core operation is outstanding.
- `public_valid`  out  1: one-cycle pulse; `public_key` is updated in the same cycle.
- `public_key`  out  255: last computed public key, held until the next public result.
- `shared_valid`  out  1: one-cycle pulse; `shared` and `shared_zero` are updated in the same cycle.
- `shared`  out  255: last shared secret.
- `shared_zero`  out  1: `shared` == 0; the result is invalid.
- `err`  out  1: one-cycle pulse when a request is rejected.
- `core_start`  out  1: start pulse to the core.
- `core_scalar`  out  255: scalar to the core.
- `core_point`  out  255: point to the core.
- `core_done`  in  1: core done.
- `core_out`  in  255: core result.

## Operation
- States: IDLE, PUB_RUN, KEYED, SH_RUN.
- Clamping: the stored scalar is {1'b1, secret[253:3], 3'b000}. `secret[254]` is ignored.
- IDLE or KEYED, on `load`:
  - Store the clamped scalar.
  - Drive `core_scalar`=clamped, `core_point`=BASE_U, `core_start`=1 for one cycle.
  - Go to PUB_RUN.
- KEYED, on `peer_valid` without `load`:
  - Drive `core_scalar`=stored scalar, `core_point`=peer_key, `core_start`=1.
  - Go to SH_RUN.
- PUB_RUN, on accepted done: latch `public_key`=`core_out`, pulse `public_valid`, go to KEYED.
- SH_RUN, on accepted done: latch `shared`=`core_out`, set `shared_zero`, pulse `shared_valid`, go to KEYED.
- Done acceptance:
  - The core holds `done` high between operations.
  - An `armed` flag is cleared on each `core_start`.
  - `armed` is set when `core_done` is sampled low.
  - `core_done` counts only when `armed`=1 and `core_done`=1.
- Rejections (pulse `err`, no state change):
  - `peer_valid` in IDLE.
  - `load` or `peer_valid` in PUB_RUN or SH_RUN.
  - `load` and `peer_valid` together in KEYED: `load` wins and `peer_valid` is rejected.
- `busy` = state ∈ {PUB_RUN, SH_RUN}.
- `core_scalar`/`core_point` are registered and held stable from the start cycle until the next start.

## Timing
- Request accepted at edge N: `core_start`=1 during cycle N+1 only; `busy`=1 from N+1.
- First accepted done sampled at edge M: `public_valid`/`shared_valid` high during cycle M+1; `busy`=0 from M+1.
- A new request is accepted at edge M+1 at the earliest.
- `err` asserts the cycle after the rejected request.
- Reset values:
  - state IDLE; `armed`=0.
  - `busy`, `public_valid`, `shared_valid`, `shared_zero`, `err`, `core_start` = 0.
  - `public_key`, `shared`, `core_scalar`, `core_point` and the stored scalar = 0. The secret is zeroized.
- Reset mid-operation:
  - Abandon the operation; no result pulse is generated.
  - The core has no reset, so the next operation relies on `armed` and does not take a stale done.

## Structure
- Shared package `x25519_pkg`: the `fe_t` 255-bit typedef, the `BASE_U` default, the state enum and the `clamp()` function. The enum and `clamp()` are reused by key-management blocks.
- No sub-module inside the block. The `curve25519` core is instantiated beside it at the next level up (`x25519_dh_top`).
- Expected size is about 150 lines.

## Test plan
- Public key: reset, then `load` with `secret`=0.
  - `core_scalar`=1<<254 and `core_point`=9, with `core_start` high exactly one cycle.
  - Using the real core, `public_valid` pulses and `public_key` equals an independent software X25519 of the clamped scalar.
- Full exchange with two instances and random secrets a and b:
  - Cross-feed each instance's `public_key` as the other's `peer_key`.
  - Both `shared` values are equal; `shared_zero`=0.
- Low-order point: `peer_key`=0 in KEYED -> `shared`=0 and `shared_zero`=1.
- Rejections:
  - `peer_valid` in IDLE -> `err` pulse, state stays IDLE.
  - `load` during PUB_RUN -> `err` pulse and `core_start` stays 0.
  - `load` and `peer_valid` together in KEYED -> new public key computed and `err` pulses once.
- Stale done: use a core model that holds `done`=1 for 3 cycles after `start`. No result pulse until `done` has gone low and then high again.
- Reset mid-operation: assert `reset` during SH_RUN.
  - Outputs return to zero; no `shared_valid` pulse.
  - A following `load` completes correctly.
